// File: rtl/aplic_domain_route.sv
// ============================================================================
// aplic_domain_route : walks the APLIC delegation tree to find a source's owner
// Optional statistics counters: APLIC_DOMAIN_ROUTE_STATS_EN   | Rev 1.0
// ============================================================================
`default_nettype none

module aplic_domain_route #(
  parameter int NrDomains   = 3,
  parameter int NrSources   = 32,
  parameter int NrChildsMax = 2,
  parameter int MaxDepth    = 4,
  parameter int SrcW        = $clog2(NrSources)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [SrcW-1:0]                 req_src_i,
  output logic                            cfg_rd_en_o,
  output logic [9:0]                      cfg_rd_dom_o,
  output logic [SrcW-1:0]                 cfg_rd_src_o,
  input  logic [10:0]                     cfg_rd_data_i,
  input  logic [NrDomains*16-1:0]         nr_childs_i,
  input  logic [NrDomains*NrChildsMax*10-1:0] child_tbl_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [9:0]                      rsp_dom_o,
  output logic [2:0]                      rsp_sm_o,
  output logic [2:0]                      rsp_depth_o,
  output logic                            rsp_err_o,
  output logic [15:0]                     stat_ok_o,
  output logic [15:0]                     stat_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EVAL = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      cur_dom_q, cur_dom_d;
  logic [SrcW-1:0] src_q, src_d;
  logic [2:0]      depth_q, depth_d;
  logic [2:0]      sm_q, sm_d;
  logic            err_q, err_d;

  logic [9:0]      child_idx;
  logic [15:0]     nr_cur;
  logic [9:0]      next_dom;
  logic            walk_err;

  assign child_idx = cfg_rd_data_i[9:0];

  // Table lookups for the current domain; cur_dom never leaves [0, NrDomains)
  always_comb begin
    nr_cur   = '0;
    next_dom = '0;
    for (int d = 0; d < NrDomains; d++) begin
      if (cur_dom_q == 10'(d)) begin
        nr_cur = nr_childs_i[d*16 +: 16];
        for (int c = 0; c < NrChildsMax; c++) begin
          if (child_idx == 10'(c)) begin
            next_dom = child_tbl_i[(d*NrChildsMax + c)*10 +: 10];
          end
        end
      end
    end
  end

  always_comb begin
    walk_err = 1'b0;
    if (32'(child_idx) >= 32'(nr_cur) || 32'(child_idx) >= 32'(NrChildsMax)) begin
      walk_err = 1'b1;
    end else if (32'(next_dom) >= 32'(NrDomains)) begin
      walk_err = 1'b1;
    end else if (32'(depth_q) + 32'd1 == 32'(MaxDepth)) begin
      walk_err = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_dom_d = cur_dom_q;
    src_d     = src_q;
    depth_d   = depth_q;
    sm_d      = sm_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          cur_dom_d = '0;
          depth_d   = '0;
          sm_d      = '0;
          err_d     = 1'b0;
          if (req_src_i == '0 || 32'(req_src_i) >= 32'(NrSources)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            src_d   = req_src_i;
            state_d = READ;
          end
        end
      end
      READ: state_d = EVAL;
      EVAL: begin
        if (!cfg_rd_data_i[10]) begin
          sm_d    = cfg_rd_data_i[2:0];
          state_d = RESP;
        end else if (walk_err) begin
          err_d   = 1'b1;
          sm_d    = '0;
          state_d = RESP;
        end else begin
          cur_dom_d = next_dom;
          depth_d   = depth_q + 3'd1;
          state_d   = READ;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cur_dom_q <= '0;
      src_q     <= '0;
      depth_q   <= '0;
      sm_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_dom_q <= cur_dom_d;
      src_q     <= src_d;
      depth_q   <= depth_d;
      sm_q      <= sm_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign cfg_rd_en_o  = (state_q == READ);
  assign cfg_rd_dom_o = cfg_rd_en_o ? cur_dom_q : '0;
  assign cfg_rd_src_o = cfg_rd_en_o ? src_q : '0;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_dom_o    = cur_dom_q;
  assign rsp_sm_o     = sm_q;
  assign rsp_depth_o  = depth_q;
  assign rsp_err_o    = err_q;

`ifdef APLIC_DOMAIN_ROUTE_STATS_EN
  logic [15:0] stat_ok_q, stat_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_ok_q  <= '0;
      stat_err_q <= '0;
    end else if (rsp_valid_o && rsp_ready_i) begin
      if (err_q) begin
        if (stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
      end else begin
        if (stat_ok_q != 16'hFFFF) stat_ok_q <= stat_ok_q + 16'd1;
      end
    end
  end

  assign stat_ok_o  = stat_ok_q;
  assign stat_err_o = stat_err_q;
`else
  assign stat_ok_o  = '0;
  assign stat_err_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aplic_domain_route.sv
// ============================================================================
// tb_aplic_domain_route : randomized lookups against a tree-walk reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aplic_domain_route;

  localparam int ND = 3;
  localparam int NS = 32;
  localparam int NC = 2;
  localparam int MD = 4;
  localparam int SW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [SW-1:0]     req_src_i;
  logic              cfg_rd_en_o;
  logic [9:0]        cfg_rd_dom_o;
  logic [SW-1:0]     cfg_rd_src_o;
  logic [10:0]       cfg_rd_data_i;
  logic [ND*16-1:0]  nr_childs_i;
  logic [ND*NC*10-1:0] child_tbl_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [9:0]        rsp_dom_o;
  logic [2:0]        rsp_sm_o;
  logic [2:0]        rsp_depth_o;
  logic              rsp_err_o;
  logic [15:0]       stat_ok_o;
  logic [15:0]       stat_err_o;

  aplic_domain_route #(
    .NrDomains(ND), .NrSources(NS), .NrChildsMax(NC), .MaxDepth(MD), .SrcW(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_src_i(req_src_i),
    .cfg_rd_en_o(cfg_rd_en_o), .cfg_rd_dom_o(cfg_rd_dom_o), .cfg_rd_src_o(cfg_rd_src_o),
    .cfg_rd_data_i(cfg_rd_data_i), .nr_childs_i(nr_childs_i), .child_tbl_i(child_tbl_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dom_o(rsp_dom_o),
    .rsp_sm_o(rsp_sm_o), .rsp_depth_o(rsp_depth_o), .rsp_err_o(rsp_err_o),
    .stat_ok_o(stat_ok_o), .stat_err_o(stat_err_o)
  );

  always #5 clk = ~clk;

  logic [10:0] mem [ND][NS];
  int nr  [ND];
  int tbl [ND][NC];

  int checks   = 0;
  int failures = 0;
  int nreads   = 0;
  int stray    = 0;
  int exp_ok   = 0;
  int exp_err  = 0;
  int rd_doms [$];
  logic rd_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_tables();
    for (int d = 0; d < ND; d++) begin
      nr_childs_i[d*16 +: 16] = 16'(nr[d]);
      for (int c = 0; c < NC; c++) child_tbl_i[(d*NC + c)*10 +: 10] = 10'(tbl[d][c]);
    end
  endtask

  task automatic randomize_env();
    for (int d = 0; d < ND; d++) begin
      nr[d] = $urandom_range(0, NC);
      for (int c = 0; c < NC; c++) tbl[d][c] = $urandom_range(0, ND);
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(0, 1) == 1) mem[d][s] = {1'b1, 10'($urandom_range(0, 3))};
        else                           mem[d][s] = {1'b0, 10'($urandom)};
      end
    end
    apply_tables();
  endtask

  // Sourcecfg memory: data presented in the cycle after the read strobe, garbage otherwise
  always @(negedge clk) begin
    int d, s;
    d = int'(cfg_rd_dom_o);
    s = int'(cfg_rd_src_o);
    if (cfg_rd_en_o) begin
      cfg_rd_data_i = (d < ND) ? mem[d][s] : 11'h7FF;
      nreads++;
      rd_doms.push_back(d);
      rd_pending = 1'b1;
    end else begin
      if (d != 0 || s != 0) stray++;
      if (!rd_pending) cfg_rd_data_i = 11'($urandom);
      rd_pending = 1'b0;
    end
  end

  // Reference: walk the delegation tree directly from the tables
  task automatic model(input int src, output int dom, output int sm, output int dep,
                       output int err, output int rd);
    logic [10:0] c;
    int idx, nxt;
    dom = 0; sm = 0; dep = 0; err = 0; rd = 0;
    if (src == 0 || src >= NS) begin
      err = 1;
      return;
    end
    while (1) begin
      rd++;
      c = mem[dom][src];
      if (!c[10]) begin
        sm = int'(c[2:0]);
        return;
      end
      idx = int'(c[9:0]);
      if (idx >= nr[dom] || idx >= NC) begin err = 1; return; end
      nxt = tbl[dom][idx];
      if (nxt >= ND) begin err = 1; return; end
      if (dep + 1 == MD) begin err = 1; return; end
      dom = nxt;
      dep++;
    end
  endtask

  task automatic check_stats();
`ifdef APLIC_DOMAIN_ROUTE_STATS_EN
    check("stat_ok", 32'(stat_ok_o), exp_ok);
    check("stat_err", 32'(stat_err_o), exp_err);
`else
    check("stat_ok", 32'(stat_ok_o), 0);
    check("stat_err", 32'(stat_err_o), 0);
`endif
  endtask

  // Called at a negedge with the DUT idle
  task automatic lookup(input int src, input int hold);
    int edom, esm, edep, eerr, erd, lat;
    model(src, edom, esm, edep, eerr, erd);
    nreads = 0;
    rd_doms.delete();
    rsp_ready_i = (hold == 0);
    check("req_ready_idle", 32'(req_ready_o), 1);
    req_valid_i = 1'b1;
    req_src_i   = SW'(src);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid_i = 1'b0;
      lat++;
    end while (!rsp_valid_o && lat < 200);
    check("latency", lat, 1 + 2*erd);
    check("rsp_dom", 32'(rsp_dom_o), edom);
    check("rsp_sm", 32'(rsp_sm_o), esm);
    check("rsp_depth", 32'(rsp_depth_o), edep);
    check("rsp_err", 32'(rsp_err_o), eerr);
    check("nreads", nreads, erd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid_o), 1);
      check("hold_ready", 32'(req_ready_o), 0);
      check("hold_stable", {rsp_dom_o, rsp_sm_o, rsp_depth_o, rsp_err_o},
            {10'(edom), 3'(esm), 3'(edep), 1'(eerr)});
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    if (eerr != 0) exp_err++; else exp_ok++;
    check("post_valid", 32'(rsp_valid_o), 0);
    check("post_ready", 32'(req_ready_o), 1);
    check_stats();
  endtask

  initial begin
    int lat;
    rst = 1'b1; req_valid_i = 1'b0; req_src_i = '0; rsp_ready_i = 1'b0;
    cfg_rd_data_i = '0;
    randomize_env();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready_o), 1);
    check("rst_cfg_en", 32'(cfg_rd_en_o), 0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check("rst_rsp", {rsp_dom_o, rsp_sm_o, rsp_depth_o, rsp_err_o}, 0);
    check_stats();

    // Root-owned source
    mem[0][5] = {1'b0, 7'd0, 3'd6};
    lookup(5, 0);

    // One hop: root -> domain 2
    nr[0] = 2; tbl[0][1] = 2;
    mem[0][7] = {1'b1, 10'd1};
    mem[2][7] = {1'b0, 7'd0, 3'd4};
    apply_tables();
    lookup(7, 0);
    check("hop_reads", rd_doms.size(), 2);
    if (rd_doms.size() == 2) begin
      check("hop_dom0", rd_doms[0], 0);
      check("hop_dom1", rd_doms[1], 2);
    end

    // Child index beyond child count
    mem[0][9] = {1'b1, 10'd3};
    lookup(9, 0);

    // Delegation cycle 0 -> 1 -> 2 -> 0 trips the depth guard
    for (int d = 0; d < ND; d++) begin
      nr[d] = 2;
      tbl[d][0] = (d + 1) % ND;
      mem[d][11] = {1'b1, 10'd0};
    end
    apply_tables();
    lookup(11, 0);

    // Reserved source with a held-off response
    lookup(0, 5);

    // Reset mid-walk
    mem[0][13] = {1'b1, 10'd0};
    mem[1][13] = {1'b1, 10'd0};
    mem[2][13] = {1'b0, 7'd0, 3'd2};
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    req_src_i   = SW'(13);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid_i = 1'b0;
      lat++;
    end while (!cfg_rd_en_o && lat < 50);
    check("rst_walk_read", 32'(cfg_rd_en_o), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ok = 0; exp_err = 0;
    check("midrst_valid", 32'(rsp_valid_o), 0);
    check("midrst_ready", 32'(req_ready_o), 1);
    check("midrst_cfg_en", 32'(cfg_rd_en_o), 0);
    check_stats();
    lookup(13, 0);

    for (int n = 0; n < 40; n++) begin
      randomize_env();
      lookup($urandom_range(0, NS - 1), $urandom_range(0, 2));
    end

    check("stray_rd_addr", stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
